// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// address/data typedefs and a small helper used by the read path.
package regfile_pkg;

   // Default geometry of the dual-issue core's integer file.
   localparam int DEF_DW    = 32;
   localparam int DEF_DEPTH = 32;
   localparam int DEF_NR    = 4;
   localparam int DEF_NW    = 2;
   localparam int DEF_AW    = $clog2(DEF_DEPTH);

   typedef logic [DEF_AW-1:0] reg_addr_t;
   typedef logic [DEF_DW-1:0] reg_data_t;

   // True when the address is register 0 and that register is hardwired to zero.
   function automatic bit is_zero_reg(input int unsigned addr, input int zero_reg);
      return (zero_reg != 0) && (addr == 0);
   endfunction

endpackage

// File: rtl/rf_write_merge.sv
// Folds NW writeback ports and NW claim ports into per-register controls:
// write enable, selected write data, busy-set and busy-clear. The global
// enable and the hardwired-zero register are applied here, so the top level
// only has to act on the per-register signals.
module rf_write_merge
   import regfile_pkg::*;
#(
   parameter int DW       = DEF_DW,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NW       = DEF_NW,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(DEPTH)
) (
   input  logic                      en,
   input  logic [NW-1:0]             wr_en,
   input  logic [NW-1:0][AW-1:0]     wr_addr,
   input  logic [NW-1:0][DW-1:0]     wr_data,
   input  logic [NW-1:0]             claim_en,
   input  logic [NW-1:0][AW-1:0]     claim_addr,
   output logic [DEPTH-1:0]          reg_we,
   output logic [DEPTH-1:0][DW-1:0]  reg_wdata,
   output logic [DEPTH-1:0]          busy_set,
   output logic [DEPTH-1:0]          busy_clr
);

   // Decode every write/claim port into per-register controls.
   always_comb begin
      // NOTE: every output gets a default before any conditional assignment,
      // otherwise paths that skip an assignment would infer latches.
      reg_we    = '0;
      reg_wdata = '0;
      busy_set  = '0;
      busy_clr  = '0;
      if (en) begin
         // NOTE: blocking assignments in a loop let a later (higher-numbered)
         // port overwrite an earlier one, which is exactly the collision rule.
         for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
               reg_we[wr_addr[p]]    = 1'b1;
               reg_wdata[wr_addr[p]] = wr_data[p];
               busy_clr[wr_addr[p]]  = 1'b1;
            end
            // Duplicate claims simply set the same bit twice.
            if (claim_en[p]) begin
               busy_set[claim_addr[p]] = 1'b1;
            end
         end
         // Hardwired zero register: writes and claims to it vanish.
         if (ZERO_REG != 0) begin
            reg_we[0]    = 1'b0;
            reg_wdata[0] = '0;
            busy_set[0]  = 1'b0;
            busy_clr[0]  = 1'b0;
         end
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised NR-read / NW-write integer register file with a per-register
// pending (busy) scoreboard. Decode claims destinations through claim_en /
// claim_addr; writeback clears them. A claim and a clear of the same register
// in one cycle leave it busy, since a newer producer has been issued.
//
// Build option: define REGFILE_BYPASS_EN to forward same-cycle write data
// (and the matching busy clear) combinationally onto the read ports.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter  int DW       = DEF_DW,
   parameter  int DEPTH    = DEF_DEPTH,
   parameter  int NR       = DEF_NR,
   parameter  int NW       = DEF_NW,
   parameter  int ZERO_REG = 1,
   localparam int AW       = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic [NW-1:0]          wr_en,
   input  logic [NW-1:0][AW-1:0]  wr_addr,
   input  logic [NW-1:0][DW-1:0]  wr_data,
   input  logic [NW-1:0]          claim_en,
   input  logic [NW-1:0][AW-1:0]  claim_addr,
   input  logic [NR-1:0][AW-1:0]  rd_addr,
   output logic [NR-1:0][DW-1:0]  rd_data,
   output logic [NR-1:0]          rd_busy,
   output logic [DEPTH-1:0]       busy_vec
);

   logic [DEPTH-1:0][DW-1:0] regs;
   logic [DEPTH-1:0]         busy_q;

   logic [DEPTH-1:0]         reg_we;
   logic [DEPTH-1:0][DW-1:0] reg_wdata;
   logic [DEPTH-1:0]         busy_set;
   logic [DEPTH-1:0]         busy_clr;

   rf_write_merge #(
      .DW       (DW),
      .DEPTH    (DEPTH),
      .NW       (NW),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_merge (
      .en         (en),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .claim_en   (claim_en),
      .claim_addr (claim_addr),
      .reg_we     (reg_we),
      .reg_wdata  (reg_wdata),
      .busy_set   (busy_set),
      .busy_clr   (busy_clr)
   );

   // Register storage: capture merged write data, clear everything on reset.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: the array is flop-based and must read zero straight out of
      // reset, so it is cleared here rather than mapped to a RAM macro.
      if (rst) begin
         regs <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (reg_we[r]) begin
               regs[r] <= reg_wdata[r];
            end
         end
      end
   end

   // Scoreboard: set on claim, clear on writeback, set wins on a tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy_q <= '0;
      end else begin
         for (int r = 0; r < DEPTH; r++) begin
            if (busy_set[r]) begin
               busy_q[r] <= 1'b1;
            end else if (busy_clr[r]) begin
               busy_q[r] <= 1'b0;
            end
         end
      end
   end

   assign busy_vec = busy_q;

   // Read muxes with optional same-cycle write forwarding.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int i = 0; i < NR; i++) begin
         rd_data[i] = regs[rd_addr[i]];
         rd_busy[i] = busy_q[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
         // reg_we is already qualified by en and the zero register; rst keeps
         // junk write traffic from leaking onto the outputs during reset.
         if (reg_we[rd_addr[i]] && !rst) begin
            rd_data[i] = reg_wdata[rd_addr[i]];
            rd_busy[i] = busy_set[rd_addr[i]];
         end
`endif
         if (is_zero_reg(32'(rd_addr[i]), ZERO_REG)) begin
            rd_data[i] = '0;
            rd_busy[i] = 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp. Stimulus pushes hand-computed expectations
// into a queue right after each rising edge; a monitor pops and compares them
// on the falling edge. A second instance with ZERO_REG=0 shares all inputs.
module tb_regfile_mp;
   import regfile_pkg::*;

   localparam int DW    = DEF_DW;
   localparam int DEPTH = DEF_DEPTH;
   localparam int NR    = DEF_NR;
   localparam int NW    = DEF_NW;
   localparam int AW    = DEF_AW;

   logic                  clk = 1'b0;
   logic                  rst;
   logic                  en;
   logic [NW-1:0]         wr_en;
   logic [NW-1:0][AW-1:0] wr_addr;
   logic [NW-1:0][DW-1:0] wr_data;
   logic [NW-1:0]         claim_en;
   logic [NW-1:0][AW-1:0] claim_addr;
   logic [NR-1:0][AW-1:0] rd_addr;
   logic [NR-1:0][DW-1:0] rd_data, nz_rd_data;
   logic [NR-1:0]         rd_busy, nz_rd_busy;
   logic [DEPTH-1:0]      busy_vec, nz_busy_vec;

   regfile_mp #(.ZERO_REG(1)) dut (
      .clk(clk), .rst(rst), .en(en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .busy_vec(busy_vec)
   );

   regfile_mp #(.ZERO_REG(0)) dut_nz (
      .clk(clk), .rst(rst), .en(en),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .claim_en(claim_en), .claim_addr(claim_addr),
      .rd_addr(rd_addr), .rd_data(nz_rd_data), .rd_busy(nz_rd_busy),
      .busy_vec(nz_busy_vec)
   );

   always #5 clk = ~clk;

   typedef enum {K_DATA, K_BUSY, K_VEC, K_NZDATA} kind_t;
   typedef struct {
      kind_t       kind;
      int          port;
      logic [31:0] exp_v;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp_v);
      end
   endtask

   task automatic expect_v(input kind_t kind, input int port, input logic [31:0] exp_v,
                           input string name);
      exp_t e;
      e.kind  = kind;
      e.port  = port;
      e.exp_v = exp_v;
      e.name  = name;
      sb.push_back(e);
   endtask

   // Monitor: compare every queued expectation away from the active edge.
   exp_t        m_e;
   logic [31:0] m_act;
   always @(negedge clk) begin
      while (sb.size() > 0) begin
         m_e = sb.pop_front();
         case (m_e.kind)
            K_DATA:   m_act = rd_data[m_e.port];
            K_BUSY:   m_act = {31'd0, rd_busy[m_e.port]};
            K_VEC:    m_act = busy_vec;
            default:  m_act = nz_rd_data[m_e.port];
         endcase
         check(m_e.name, m_act, m_e.exp_v);
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      en       = 1'b1;
      wr_en    = '0;
      claim_en = '0;
   endtask

   task automatic set_wr(input int p, input int a, input logic [31:0] d);
      wr_en[p]   = 1'b1;
      wr_addr[p] = AW'(a);
      wr_data[p] = d;
   endtask

   task automatic set_claim(input int p, input int a);
      claim_en[p]   = 1'b1;
      claim_addr[p] = AW'(a);
   endtask

   task automatic set_rd(input int p, input int a);
      rd_addr[p] = AW'(a);
   endtask

   // Watchdog: the stimulus is finite, but never let the run hang.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // Reset with junk on every input.
      rst        = 1'b1;
      en         = 1'b1;
      wr_en      = '1;
      wr_addr    = {5'd3, 5'd17};
      wr_data    = {32'hFFFF_FFFF, 32'h5A5A_A5A5};
      claim_en   = '1;
      claim_addr = {5'd9, 5'd22};
      rd_addr    = {5'd31, 5'd17, 5'd3, 5'd1};
      next_cycle();
      next_cycle();
      for (int p = 0; p < NR; p++) begin
         expect_v(K_DATA, p, 32'h0, $sformatf("reset_rd_data%0d", p));
         expect_v(K_BUSY, p, 32'h0, $sformatf("reset_rd_busy%0d", p));
      end
      expect_v(K_VEC, 0, 32'h0, "reset_busy_vec");

      // Release reset and sweep registers 1..31.
      next_cycle();
      rst = 1'b0;
      idle();
      for (int c = 0; c < 8; c++) begin
         next_cycle();
         for (int p = 0; p < NR; p++) begin
            if (1 + c * NR + p < DEPTH) begin
               set_rd(p, 1 + c * NR + p);
               expect_v(K_DATA, p, 32'h0, $sformatf("post_reset_reg%0d", 1 + c * NR + p));
            end
         end
      end

      // Port priority on a shared address, then on register 0.
      next_cycle();
      set_wr(0, 5, 32'hAAAA_0000);
      set_wr(1, 5, 32'h1234_5678);
      next_cycle();
      idle();
      set_wr(0, 0, 32'hAAAA_0000);
      set_wr(1, 0, 32'h1234_5678);
      set_rd(0, 5);
      expect_v(K_DATA, 0, 32'h1234_5678, "prio_reg5");
      next_cycle();
      idle();
      set_rd(1, 0);
      expect_v(K_DATA, 1, 32'h0, "zero_reg_write_dropped");
      expect_v(K_NZDATA, 1, 32'h1234_5678, "nonzero_cfg_reg0_prio");

      // Scoreboard: claim reg7, hold, then write it back.
      next_cycle();
      set_claim(0, 7);
      set_rd(2, 7);
      expect_v(K_BUSY, 2, 32'h0, "claim_cycle_busy7");
      next_cycle();
      idle();
      expect_v(K_BUSY, 2, 32'h1, "busy7_after_claim");
      expect_v(K_VEC, 0, 32'h0000_0080, "busy_vec_bit7");
      next_cycle();
      expect_v(K_BUSY, 2, 32'h1, "busy7_held");
      next_cycle();
      set_wr(0, 7, 32'hDEAD_BEEF);
`ifdef REGFILE_BYPASS_EN
      expect_v(K_DATA, 2, 32'hDEAD_BEEF, "wb_cycle_data7");
      expect_v(K_BUSY, 2, 32'h0, "wb_cycle_busy7");
`else
      expect_v(K_DATA, 2, 32'h0, "wb_cycle_data7");
      expect_v(K_BUSY, 2, 32'h1, "wb_cycle_busy7");
`endif
      next_cycle();
      idle();
      expect_v(K_DATA, 2, 32'hDEAD_BEEF, "data7_after_wb");
      expect_v(K_BUSY, 2, 32'h0, "busy7_cleared");
      expect_v(K_VEC, 0, 32'h0, "busy_vec_clear");

      // Claim and write the same register in one cycle: set wins.
      next_cycle();
      set_claim(0, 9);
      set_wr(1, 9, 32'h55);
      next_cycle();
      idle();
      set_rd(3, 9);
      expect_v(K_DATA, 3, 32'h55, "set_clr_data9");
      expect_v(K_BUSY, 3, 32'h1, "set_clr_busy9");
      expect_v(K_VEC, 0, 32'h0000_0200, "busy_vec_bit9");

      // en=0 freezes writes and claims.
      next_cycle();
      en = 1'b0;
      set_wr(0, 3, 32'h77);
      set_claim(1, 4);
      set_rd(0, 3);
      expect_v(K_DATA, 0, 32'h0, "en0_cycle_reg3");
      next_cycle();
      idle();
      set_rd(1, 4);
      expect_v(K_DATA, 0, 32'h0, "en0_reg3_unchanged");
      expect_v(K_BUSY, 1, 32'h0, "en0_claim4_ignored");
      expect_v(K_VEC, 0, 32'h0000_0200, "en0_busy_vec");

      // Same-cycle read of a register being written (non-busy target).
      next_cycle();
      set_wr(0, 12, 32'h1111);
      next_cycle();
      idle();
      set_wr(0, 12, 32'hCAFE);
      set_rd(0, 12);
`ifdef REGFILE_BYPASS_EN
      expect_v(K_DATA, 0, 32'hCAFE, "bypass_cycle_reg12");
`else
      expect_v(K_DATA, 0, 32'h1111, "bypass_cycle_reg12");
`endif
      expect_v(K_BUSY, 0, 32'h0, "bypass_cycle_busy12");
      next_cycle();
      idle();
      expect_v(K_DATA, 0, 32'hCAFE, "reg12_after_write");
      expect_v(K_BUSY, 0, 32'h0, "reg12_not_busy");

      // Write and re-claim of the same register, read in the same cycle.
      next_cycle();
      set_wr(0, 13, 32'h5);
      set_claim(1, 13);
      set_rd(1, 13);
`ifdef REGFILE_BYPASS_EN
      expect_v(K_DATA, 1, 32'h5, "bypass_claim_data13");
      expect_v(K_BUSY, 1, 32'h1, "bypass_claim_busy13");
`else
      expect_v(K_DATA, 1, 32'h0, "bypass_claim_data13");
      expect_v(K_BUSY, 1, 32'h0, "bypass_claim_busy13");
`endif
      next_cycle();
      idle();
      expect_v(K_DATA, 1, 32'h5, "reg13_after");
      expect_v(K_BUSY, 1, 32'h1, "busy13_after");

      // Duplicate claims, and claims to the zero register.
      next_cycle();
      set_claim(0, 14);
      set_claim(1, 14);
      next_cycle();
      idle();
      set_claim(0, 0);
      set_claim(1, 0);
      set_rd(2, 14);
      expect_v(K_BUSY, 2, 32'h1, "dup_claim_busy14");
      next_cycle();
      idle();
      set_rd(0, 0);
      expect_v(K_BUSY, 0, 32'h0, "zero_reg_claim_ignored");
      expect_v(K_VEC, 0, 32'h0000_6200, "busy_vec_9_13_14");

      // Asynchronous reset mid-operation.
      next_cycle();
      set_claim(0, 20);
      set_wr(1, 21, 32'h99);
      next_cycle();
      set_rd(0, 21);
      expect_v(K_DATA, 0, 32'h99, "pre_reset_reg21");
      expect_v(K_BUSY, 0, 32'h0, "pre_reset_busy21");
      expect_v(K_VEC, 0, 32'h0010_6200, "pre_reset_busy_vec");
      next_cycle();
      expect_v(K_VEC, 0, 32'h0, "async_reset_busy_vec");
      expect_v(K_DATA, 0, 32'h0, "async_reset_reg21");
      #1;
      rst = 1'b1;
      #5;
      rst = 1'b0;
      idle();
      next_cycle();
      set_rd(1, 5);
      expect_v(K_DATA, 0, 32'h0, "after_reset_reg21");
      expect_v(K_DATA, 1, 32'h0, "after_reset_reg5");
      expect_v(K_VEC, 0, 32'h0, "after_reset_busy_vec");

      // Let the monitor drain, then confirm nothing was left unchecked.
      next_cycle();
      next_cycle();
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file with a per-register pending scoreboard, serving the dual-issue core's decode/operand-read and writeback stages. It generalises the fixed 4-read/2-write file to NR read and NW write ports, configurable width and depth, and an optional hardwired-zero register. Each register carries a busy bit: it is set when an instruction claims the register as its destination and cleared on writeback. Decode stalls on these bits instead of running a separate hazard unit.

## Interface
Parameters:
- DW, 32, data width in bits
- DEPTH, 32, number of architectural registers (power of two, ≥2)
- NR, 4, read ports
- NW, 2, write ports; also the number of claim ports
- ZERO_REG, 1, when 1 register 0 reads as zero and is never written or marked busy
- AW, $clog2(DEPTH), localparam address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- en  in  1  global enable; when low, no register or busy-bit state changes
- wr_en  in  NW  writeback valid per port
- wr_addr  in  NW×AW  writeback destination
- wr_data  in  NW×DW  writeback data
- claim_en  in  NW  issue-time destination claim per port
- claim_addr  in  NW×AW  claimed destination
- rd_addr  in  NR×AW  read addresses
- rd_data  out  NR×DW  read data, combinational
- rd_busy  out  NR  addressed register pending, combinational
- busy_vec  out  DEPTH  raw scoreboard state

## Operation
- Reset: all registers are 0, busy_vec is all-zero, rd_data is 0, and rd_busy is 0.
- Writes: on a rising clk with en=1, each port i with wr_en[i]=1 writes wr_data[i] to wr_addr[i].
- Write collision: if several ports target the same address in one cycle, the highest-numbered port wins.
- Busy clear: a write clears busy[wr_addr[i]].
- Busy set: claim_en[i]=1 sets busy[claim_addr[i]].
- Set and clear in the same cycle on the same register: set wins. The bit ends at 1 because a new producer has been issued.
- Duplicate claims to one address in one cycle set the bit once, with no error.
- Register 0 with ZERO_REG=1: writes are dropped, claims are ignored, busy[0] stays 0, and reads return 0.
- Register 0 with ZERO_REG=0: register 0 behaves like any other register.
- en=0: writes and claims are both ignored for that cycle. Reads remain live.
- Write to a register that is not busy: the write is legal, the data is updated, and the busy bit stays 0.

## Timing
- Write latency: without bypass, data written at edge k is visible on rd_data after edge k. Without bypass, a write cycle reads the old value.
- Busy update: the bit updates at the clock edge. rd_busy reflects the registered busy bit, modified by bypass when REGFILE_BYPASS_EN is defined.
- Reset mid-operation: asserting rst immediately clears all state, regardless of clk or en. Any in-flight claim or write is lost.
- Combinational paths: only the rd_addr → rd_data/rd_busy path is combinational. When bypass is enabled, the paths from wr_en, wr_addr and wr_data also reach the read outputs combinationally.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read whose rd_addr matches an active write this cycle returns that write's data combinationally. When several writes match, the highest port wins.
  - rd_busy is forced to 0 for that read unless the same address is also claimed this cycle.
  - Bypass applies only when en=1 and the address is not the zero register with ZERO_REG=1.
- REGFILE_BYPASS_EN undefined: reads return registered contents only, and rd_busy equals the registered busy bit.

## Structure
- Shared package regfile_pkg holds:
  - the default DW, DEPTH, NR and NW constants
  - the typedefs reg_addr_t and reg_data_t
- Sub-module rf_write_merge:
  - Reduces the NW write ports and NW claim ports into per-register signals: write enable, selected data (highest-port priority), busy-set and busy-clear.
  - The top level instantiates one rf_write_merge and adds the storage array, the scoreboard flops and the read muxes with optional bypass.

## Test plan
- Reset: hold rst, drive junk on all inputs → every rd_data=0, rd_busy=0, busy_vec=0. Release rst, read regs 1..31 → all read 0.
- Port priority: wr_en=2'b11, wr_addr both 5, wr_data0=0xAAAA_0000, wr_data1=0x1234_5678 → next cycle reg5 reads 0x1234_5678. Repeat with addr 0 → reg0 stays 0.
- Scoreboard: claim reg7 at cycle 1 → rd_busy=1 for reg7 from cycle 2. Write reg7=0xDEAD_BEEF at cycle 4 → busy clears and data reads back from cycle 5.
- Simultaneous events: claim reg9 on port 0 and write reg9=0x55 on port 1 in the same cycle → reg9=0x55 and busy[9]=1 afterwards. Separately, en=0 with write reg3=0x77 → reg3 is unchanged.
- Bypass, run both builds: write reg12=0xCAFE with rd_addr=12 in the same cycle.
  - Bypass build: rd_data=0xCAFE and rd_busy=0 that cycle.
  - Non-bypass build: the old value is returned and 0xCAFE appears the following cycle.
- Async reset mid-operation: with claims and writes active, pulse rst between clock edges → all state clears immediately, before the next edge.
